payload_fifo_arbiter: RTL and testbench
=======================================

PAYLOAD_FIFO_ARBITER -- requirements
Module: payload_fifo_arbiter

Interface
REQ-001 Parameter: NPORTS, 4, number of ingress requesters; fixed at 4 in this revision.
REQ-002 Parameter: MAX_LEN, 1024, maximum packet length in bytes; equals payload FIFO depth.
REQ-003 The block SHALL have one clock, CLK, and one reset, RESET_N; RESET_N is asynchronous and active-low.
REQ-004 Port: CLK  input  1  rising-edge clock for all state.
REQ-005 Port: RESET_N  input  1  asynchronous active-low reset.
REQ-006 Port: REQ_VALID  input  4  per-port byte valid.
REQ-007 Port: REQ_DATA  input  32  per-port byte; port n uses bits [8n+7:8n].
REQ-008 Port: REQ_LAST  input  4  per-port last-byte-of-packet marker, qualified by REQ_VALID.
REQ-009 Port: REQ_READY  output  4  per-port byte accept.
REQ-010 Port: FIFO_WE  output  1  payload FIFO write enable, active-high.
REQ-011 Port: FIFO_DATA  output  8  payload FIFO write data.
REQ-012 Port: FIFO_FULL  input  1  payload FIFO full flag.
REQ-013 Port: PKT_DONE  output  1  one-cycle pulse per completed packet.
REQ-014 Port: PKT_PORT  output  2  source port of the completed packet, valid with PKT_DONE.
REQ-015 Port: PKT_LEN  output  11  completed packet byte count, 1..1024, valid with PKT_DONE.
REQ-016 Port: PKT_ERR  output  1  packet force-terminated at MAX_LEN without REQ_LAST, valid with PKT_DONE.

Function
REQ-017 The FSM SHALL have two states: IDLE and XFER.
REQ-018 In IDLE with any REQ_VALID high, the block SHALL select a grant round-robin, searching from port (last_grant+1) mod 4 upward with wrap. It SHALL enter XFER on the next edge with the grant registered.
REQ-019 In IDLE, REQ_READY SHALL be 0000 and FIFO_WE SHALL be 0.
REQ-020 In XFER, REQ_READY[g] SHALL equal !FIFO_FULL, and the other REQ_READY bits SHALL be 0.
REQ-021 A transfer occurs when REQ_VALID[g] & REQ_READY[g] are both high. On a transfer, FIFO_WE SHALL be high in the same cycle (combinational, zero latency) and FIFO_DATA SHALL equal REQ_DATA of port g.
REQ-022 While FIFO_FULL is high, no transfer SHALL occur. The grant SHALL be held, and the source keeps its byte stable.
REQ-023 The grant SHALL be locked for the whole packet; other ports' requests SHALL be ignored until the packet ends.
REQ-024 The byte counter SHALL clear on entering XFER and increment by 1 per transfer.
REQ-025 A packet SHALL end on the transfer with REQ_LAST[g]=1, or on the MAX_LEN-th transfer, whichever comes first.
REQ-026 On packet end, the following SHALL happen on the next edge:
- PKT_DONE pulses for one cycle;
- PKT_PORT = g;
- PKT_LEN = byte count including the final byte;
- PKT_ERR = 1 only if REQ_LAST was 0 at the MAX_LEN-th byte;
- last_grant updates to g;
- the state returns to IDLE.
REQ-027 Minimum spacing SHALL be one IDLE cycle between packets; back-to-back packets from the same port are allowed if no other port requests.
REQ-028 After a PKT_ERR termination, further bytes from that port SHALL be treated as a new packet.
REQ-029 PKT_PORT, PKT_LEN and PKT_ERR SHALL hold their values until the next PKT_DONE.
REQ-030 REQ_VALID deasserting mid-packet SHALL stall the transfer without ending the packet or releasing the grant.

Reset
REQ-031 Assertion of RESET_N=0 SHALL immediately force the following, regardless of operation in progress; a partial packet is abandoned and no PKT_DONE is issued for it:
- state IDLE;
- last_grant=3, so port 0 has first priority;
- byte counter 0;
- PKT_DONE=0, PKT_PORT=0, PKT_LEN=0, PKT_ERR=0.
REQ-032 During reset, REQ_READY SHALL be 0000 and FIFO_WE SHALL be 0.
REQ-033 The first grant evaluation SHALL occur on the first rising CLK edge after RESET_N deasserts.

Verification
REQ-034 Single packet: after reset, port 2 sends bytes 0x11,0x22,0x33 with LAST on 0x33 and FIFO_FULL=0 -> FIFO_WE high for 3 cycles with data 11,22,33. Next cycle PKT_DONE=1, PKT_PORT=2, PKT_LEN=3, PKT_ERR=0.
REQ-035 Round-robin: all four ports continuously request 2-byte packets -> grant order 0,1,2,3,0. Exactly one PKT_DONE per packet, with one IDLE cycle between packets.
REQ-036 Backpressure: FIFO_FULL held high for 5 cycles mid-packet -> REQ_READY[g]=0 and FIFO_WE=0 for those 5 cycles, grant unchanged, no byte lost or duplicated, PKT_LEN correct.
REQ-037 Oversize: port 1 sends 1030 bytes with no LAST -> first PKT_DONE has PKT_LEN=1024 and PKT_ERR=1. The remaining 6 bytes form a new packet: PKT_LEN=6 if LAST is on byte 1030.
REQ-038 Reset mid-packet: RESET_N low after byte 4 of an 8-byte packet from port 3 -> REQ_READY=0000 and FIFO_WE=0 immediately, no PKT_DONE. The next arbitration with ports 0 and 3 requesting grants port 0.
REQ-039 Lock check: port 0 mid-packet while port 1 asserts REQ_VALID -> REQ_READY[1] stays 0 until port 0's PKT_DONE, after which port 1 is granted.

Source files
------------

// File: rtl/payload_fifo_arbiter.sv
// Round-robin packet arbiter: locks one of four byte-stream requesters per
// packet and forwards its bytes into a shared payload FIFO.
module payload_fifo_arbiter #(
  parameter int unsigned NPORTS  = 4,
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [NPORTS-1:0]     REQ_VALID,
  input  logic [NPORTS*8-1:0]   REQ_DATA,
  input  logic [NPORTS-1:0]     REQ_LAST,
  output logic [NPORTS-1:0]     REQ_READY,
  output logic                  FIFO_WE,
  output logic [7:0]            FIFO_DATA,
  input  logic                  FIFO_FULL,
  output logic                  PKT_DONE,
  output logic [1:0]            PKT_PORT,
  output logic [10:0]           PKT_LEN,
  output logic                  PKT_ERR
);

  localparam int unsigned PW = 2;
  localparam int unsigned LW = 11;

  typedef enum logic {IDLE, XFER} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [PW-1:0]   last_grant_q, last_grant_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            pkt_done_q, pkt_done_d;
  logic [PW-1:0]   pkt_port_q, pkt_port_d;
  logic [LW-1:0]   pkt_len_q, pkt_len_d;
  logic            pkt_err_q, pkt_err_d;

  logic [PW-1:0]   rr_pick;
  logic [PW-1:0]   rr_idx;
  logic            rr_found;
  logic            xfer;
  logic [LW-1:0]   cnt_inc;

  // Round-robin search starting one past the last granted port.
  always_comb begin
    rr_pick  = last_grant_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      rr_idx = PW'((32'(last_grant_q) + i) % NPORTS);
      if (!rr_found && REQ_VALID[rr_idx]) begin
        rr_pick  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign xfer    = (state_q == XFER) && REQ_VALID[grant_q] && !FIFO_FULL;
  assign cnt_inc = cnt_q + LW'(1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    pkt_done_d   = 1'b0;
    pkt_port_d   = pkt_port_q;
    pkt_len_d    = pkt_len_q;
    pkt_err_d    = pkt_err_q;
    REQ_READY    = '0;
    FIFO_WE      = 1'b0;
    FIFO_DATA    = REQ_DATA[{grant_q, 3'b000} +: 8];

    case (state_q)
      IDLE: begin
        if (|REQ_VALID) begin
          state_d = XFER;
          grant_d = rr_pick;
          cnt_d   = '0;
        end
      end
      XFER: begin
        REQ_READY[grant_q] = !FIFO_FULL;
        if (xfer) begin
          FIFO_WE = 1'b1;
          cnt_d   = cnt_inc;
          // Packet closes on LAST or when the FIFO depth worth of bytes is reached.
          if (REQ_LAST[grant_q] || (cnt_inc == LW'(MAX_LEN))) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            pkt_done_d   = 1'b1;
            pkt_port_d   = grant_q;
            pkt_len_d    = cnt_inc;
            pkt_err_d    = !REQ_LAST[grant_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= PW'(NPORTS - 1);
      cnt_q        <= '0;
      pkt_done_q   <= 1'b0;
      pkt_port_q   <= '0;
      pkt_len_q    <= '0;
      pkt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      pkt_done_q   <= pkt_done_d;
      pkt_port_q   <= pkt_port_d;
      pkt_len_q    <= pkt_len_d;
      pkt_err_q    <= pkt_err_d;
    end
  end

  assign PKT_DONE = pkt_done_q;
  assign PKT_PORT = pkt_port_q;
  assign PKT_LEN  = pkt_len_q;
  assign PKT_ERR  = pkt_err_q;

endmodule

// File: tb/tb_payload_fifo_arbiter.sv
// Directed bench for payload_fifo_arbiter: per-port byte sources feed the DUT,
// FIFO writes and packet completions are logged and compared to fixed expectations.
module tb_payload_fifo_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  REQ_VALID;
  logic [31:0] REQ_DATA;
  logic [3:0]  REQ_LAST;
  logic [3:0]  REQ_READY;
  logic        FIFO_WE;
  logic [7:0]  FIFO_DATA;
  logic        FIFO_FULL;
  logic        PKT_DONE;
  logic [1:0]  PKT_PORT;
  logic [10:0] PKT_LEN;
  logic        PKT_ERR;

  always #5 CLK = ~CLK;

  payload_fifo_arbiter dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_LAST  (REQ_LAST),
    .REQ_READY (REQ_READY),
    .FIFO_WE   (FIFO_WE),
    .FIFO_DATA (FIFO_DATA),
    .FIFO_FULL (FIFO_FULL),
    .PKT_DONE  (PKT_DONE),
    .PKT_PORT  (PKT_PORT),
    .PKT_LEN   (PKT_LEN),
    .PKT_ERR   (PKT_ERR)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ncyc = 0;
  int total[4];
  int sent[4];
  int psz[4];
  int dbase[4];
  int dstep[4];
  logic [3:0]  en;
  logic [7:0]  wr_q[$];
  logic [13:0] done_q[$];
  int          done_cyc[$];
  logic [7:0]  exp_rr[10] = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h80,
                              8'h81, 8'hC0, 8'hC1, 8'h02, 8'h03};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      logic v;
      v = en[p] && (sent[p] < total[p]);
      REQ_VALID[p]       = v;
      REQ_DATA[8*p +: 8] = 8'(dbase[p] + sent[p] * dstep[p]);
      REQ_LAST[p]        = v && (((sent[p] + 1) % psz[p]) == 0);
    end
  endtask

  // One clock: log what the DUT does this cycle, then advance sources past the edge.
  task automatic cycle();
    logic [3:0] acc;
    acc = REQ_VALID & REQ_READY;
    if (FIFO_WE === 1'b1) wr_q.push_back(FIFO_DATA);
    @(posedge CLK);
    @(negedge CLK);
    ncyc++;
    for (int p = 0; p < 4; p++) if (acc[p]) sent[p]++;
    if (PKT_DONE === 1'b1) begin
      done_q.push_back({PKT_PORT, PKT_LEN, PKT_ERR});
      done_cyc.push_back(ncyc);
    end
    drive();
    #1;
  endtask

  task automatic src_clear();
    en = '0;
    for (int p = 0; p < 4; p++) begin
      total[p] = 0; sent[p] = 0; psz[p] = 1; dbase[p] = 0; dstep[p] = 1;
    end
  endtask

  task automatic src_set(input int p, input int tot, input int sz, input int base, input int step);
    en[p] = 1'b1; total[p] = tot; sent[p] = 0; psz[p] = sz; dbase[p] = base; dstep[p] = step;
  endtask

  task automatic do_reset();
    RESET_N   = 1'b0;
    FIFO_FULL = 1'b0;
    src_clear();
    drive();
    #1;
    cycle();
    cycle();
    RESET_N = 1'b1;
    wr_q.delete();
    done_q.delete();
    done_cyc.delete();
  endtask

  task automatic wait_done(input int k, input int budget, input string tag);
    int b;
    b = budget;
    while (done_q.size() < k && b > 0) begin
      cycle();
      b--;
    end
    check({tag, "_done_cnt"}, 32'(done_q.size()), 32'(k));
  endtask

  task automatic wait_wr(input int k, input int budget, input string tag);
    int b;
    b = budget;
    while (wr_q.size() < k && b > 0) begin
      cycle();
      b--;
    end
    check({tag, "_wr_cnt"}, 32'(wr_q.size()), 32'(k));
  endtask

  initial begin
    int bad;
    int b;

    // Reset state, with a request present to show it is ignored.
    RESET_N   = 1'b0;
    FIFO_FULL = 1'b0;
    src_clear();
    src_set(0, 1, 1, 0, 1);
    drive();
    #1;
    check("rst_ready", 32'(REQ_READY), 32'h0);
    check("rst_we", 32'(FIFO_WE), 32'h0);
    cycle();
    check("rst_pkt", {PKT_DONE, PKT_PORT, PKT_LEN, PKT_ERR}, 32'h0);
    do_reset();

    // Single packet from port 2.
    src_set(2, 3, 3, 8'h11, 8'h11);
    drive();
    #1;
    check("t1_idle", {REQ_READY, FIFO_WE}, 32'h0);
    cycle();
    check("t1_b0", {REQ_READY, FIFO_WE, FIFO_DATA}, {4'b0100, 1'b1, 8'h11});
    cycle();
    check("t1_b1", {FIFO_WE, FIFO_DATA}, {1'b1, 8'h22});
    cycle();
    check("t1_b2", {FIFO_WE, FIFO_DATA}, {1'b1, 8'h33});
    cycle();
    check("t1_done", {PKT_DONE, PKT_PORT, PKT_LEN, PKT_ERR}, {1'b1, 2'd2, 11'd3, 1'b0});
    check("t1_idle_after", {REQ_READY, FIFO_WE}, 32'h0);
    cycle();
    check("t1_hold", {PKT_DONE, PKT_PORT, PKT_LEN, PKT_ERR}, {1'b0, 2'd2, 11'd3, 1'b0});

    // Round-robin with all four ports requesting 2-byte packets.
    do_reset();
    src_set(0, 4, 2, 8'h00, 1);
    src_set(1, 2, 2, 8'h40, 1);
    src_set(2, 2, 2, 8'h80, 1);
    src_set(3, 2, 2, 8'hC0, 1);
    drive();
    #1;
    wait_done(5, 40, "rr");
    check("rr_p0", done_q[0], {2'd0, 11'd2, 1'b0});
    check("rr_p1", done_q[1], {2'd1, 11'd2, 1'b0});
    check("rr_p2", done_q[2], {2'd2, 11'd2, 1'b0});
    check("rr_p3", done_q[3], {2'd3, 11'd2, 1'b0});
    check("rr_p4", done_q[4], {2'd0, 11'd2, 1'b0});
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_gap%0d", i), 32'(done_cyc[i+1] - done_cyc[i]), 32'd3);
    for (int i = 0; i < 4; i++) cycle();
    check("rr_no_extra", 32'(done_q.size()), 32'd5);
    bad = 0;
    for (int i = 0; i < 10; i++) if (wr_q[i] !== exp_rr[i]) bad++;
    check("rr_wr_cnt", 32'(wr_q.size()), 32'd10);
    check("rr_data", 32'(bad), 32'd0);

    // Backpressure: FIFO full for 5 cycles mid-packet.
    do_reset();
    src_set(1, 6, 6, 8'hA0, 1);
    drive();
    #1;
    wait_wr(2, 10, "bp");
    for (int i = 0; i < 5; i++) begin
      FIFO_FULL = 1'b1;
      #1;
      check($sformatf("bp_stall%0d", i), {REQ_READY, FIFO_WE}, 32'h0);
      cycle();
    end
    FIFO_FULL = 1'b0;
    #1;
    check("bp_grant_held", 32'(REQ_READY), 32'b0010);
    wait_done(1, 20, "bp");
    check("bp_pkt", done_q[0], {2'd1, 11'd6, 1'b0});
    check("bp_wr_cnt", 32'(wr_q.size()), 32'd6);
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== 8'(8'hA0 + i)) bad++;
    check("bp_data", 32'(bad), 32'd0);

    // Oversize: 1030 bytes from port 1, LAST only on the final byte.
    do_reset();
    src_set(1, 1030, 1030, 0, 1);
    drive();
    #1;
    wait_done(2, 1100, "ovs");
    check("ovs_pkt0", done_q[0], {2'd1, 11'd1024, 1'b1});
    check("ovs_pkt1", done_q[1], {2'd1, 11'd6, 1'b0});
    check("ovs_wr_cnt", 32'(wr_q.size()), 32'd1030);
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== 8'(i)) bad++;
    check("ovs_data", 32'(bad), 32'd0);

    // Reset mid-packet on port 3, then arbitration between ports 0 and 3.
    do_reset();
    src_set(3, 8, 8, 8'h30, 1);
    drive();
    #1;
    wait_wr(4, 10, "mr");
    check("mr_active", 32'(FIFO_WE), 32'h1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("mr_ready", 32'(REQ_READY), 32'h0);
    check("mr_we", 32'(FIFO_WE), 32'h0);
    cycle();
    cycle();
    check("mr_pkt", {PKT_DONE, PKT_PORT, PKT_LEN, PKT_ERR}, 32'h0);
    check("mr_no_done", 32'(done_q.size()), 32'd0);
    src_clear();
    src_set(0, 1, 1, 8'h5A, 1);
    src_set(3, 1, 1, 8'h3A, 1);
    drive();
    RESET_N = 1'b1;
    #1;
    wait_done(2, 20, "mr");
    check("mr_first", done_q[0], {2'd0, 11'd1, 1'b0});
    check("mr_second", done_q[1], {2'd3, 11'd1, 1'b0});

    // Grant lock: port 1 requests while port 0 is mid-packet.
    do_reset();
    src_set(0, 4, 4, 8'h10, 1);
    drive();
    #1;
    wait_wr(1, 10, "lk");
    src_set(1, 2, 2, 8'h20, 1);
    drive();
    #1;
    b = 20;
    while (done_q.size() == 0 && b > 0) begin
      check("lk_rdy1", 32'(REQ_READY[1]), 32'h0);
      cycle();
      b--;
    end
    wait_done(2, 20, "lk");
    check("lk_p0", done_q[0], {2'd0, 11'd4, 1'b0});
    check("lk_p1", done_q[1], {2'd1, 11'd2, 1'b0});
    check("lk_p1_data", 32'(wr_q[4]), 32'h20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
